uart_tx_scheduler: RTL and testbench

Shares the board's single UART `tx` line between two byte requesters: requester 0 echoes received bytes, requester 1 carries locally generated bytes. Each requester has a single-entry holding register behind a valid/ready handshake. A round-robin scheduler grants the line, and an internal frame sequencer (baud counter plus bit FSM) serialises the granted byte. It sits between the receive/decode logic and the `tx` pin.

---
 rtl/uart_tx_scheduler.sv | 143 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Two-requester UART transmitter: per-requester holding registers, round-robin grant, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk_raw,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       frame_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic          full0_q, full1_q;
  logic [7:0]    hold0_q, hold1_q;
  logic [7:0]    shift_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic          grant_q, grant_d;
  logic          prio_q, prio_d;
  logic          load;
  logic          bit_end;

  assign req0_ready = ~full0_q;
  assign req1_ready = ~full1_q;
  assign grant_id   = grant_q;
  assign bit_end    = (baud_q == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    load       = 1'b0;
    tx         = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full0_q || full1_q) begin
          grant_d = (full0_q && full1_q) ? prio_q : full1_q;
          prio_d  = ~grant_d;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        load    = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        tx   = 1'b0;
        busy = 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx   = shift_q[0];
        busy = 1'b1;
        if (bit_end && bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      // The shift register rotates, so after 8 bits it holds the original byte again.
      S_PARITY: begin
        tx   = ^shift_q;
        busy = 1'b1;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        busy = 1'b1;
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_raw) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;

      if (req0_valid && !full0_q)  full0_q <= 1'b1;
      else if (load && !grant_q)   full0_q <= 1'b0;

      if (req1_valid && !full1_q)  full1_q <= 1'b1;
      else if (load && grant_q)    full1_q <= 1'b0;

      if (busy) baud_q <= bit_end ? '0 : baud_q + BW'(1);
      else      baud_q <= '0;

      if (state_q == S_DATA && bit_end) bit_q <= bit_q + 3'd1;
      else if (state_q != S_DATA)       bit_q <= '0;
    end
  end

  // NOTE: data registers carry no reset; their contents are only consumed behind full flags and the FSM.
  always_ff @(posedge clk_raw) begin
    if (req0_valid && !full0_q) hold0_q <= req0_data;
    if (req1_valid && !full1_q) hold1_q <= req1_data;
    if (load)                             shift_q <= grant_q ? hold1_q : hold0_q;
    else if (state_q == S_DATA && bit_end) shift_q <= {shift_q[0], shift_q[7:1]};
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected frames, a tx-line monitor decodes and compares.
module tb_uart_tx_scheduler;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk_raw;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx, busy, grant_id, frame_done;

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB)) dut (
    .clk_raw    (clk_raw),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id),
    .frame_done (frame_done)
  );

  typedef struct {
    logic       gid;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   frames_seen = 0;
  int   last_gap = 0;
  logic last_parity = 1'b0;

  initial clk_raw = 1'b0;
  always #5 clk_raw = ~clk_raw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: captures whole frames from the tx line, checks framing, pops and compares.
  logic s_tx   [FL];
  logic s_done [FL];
  logic s_busy [FL];

  initial begin
    int         t, start, prev_end;
    bit         aborted, stable, done_ok, busy_ok;
    logic [7:0] rx;
    logic       s_grant;
    exp_t       e;
    t = 0;
    prev_end = -1000;
    forever begin
      @(negedge clk_raw);
      t++;
      if (!rst_n) begin
        prev_end = -1000;
      end else if (frame_done === 1'b1) begin
        check("stray_frame_done", frame_done, 1'b0);
      end else if (tx === 1'b0) begin
        start = t;
        aborted = 1'b0;
        s_tx[0] = tx; s_done[0] = frame_done; s_busy[0] = busy;
        for (int i = 1; i < FL; i++) begin
          @(negedge clk_raw);
          t++;
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s_tx[i] = tx; s_done[i] = frame_done; s_busy[i] = busy;
        end
        s_grant = grant_id;
        if (aborted) begin
          prev_end = -1000;
        end else begin
          last_gap = start - prev_end - 1;
          prev_end = t;
          stable = 1'b1; done_ok = 1'b1; busy_ok = 1'b1;
          for (int b = 0; b < NBITS; b++)
            for (int k = 1; k < CPB; k++)
              if (s_tx[b*CPB+k] !== s_tx[b*CPB]) stable = 1'b0;
          for (int i = 0; i < FL; i++) begin
            if (s_done[i] !== (i == FL - 1)) done_ok = 1'b0;
            if (s_busy[i] !== 1'b1) busy_ok = 1'b0;
          end
          for (int i = 0; i < 8; i++) rx[i] = s_tx[CPB*(i+1)];
          check("frame_bit_stable", stable, 1'b1);
          check("frame_start_bit", s_tx[0], 1'b0);
          check("frame_stop_bit", s_tx[CPB*(NBITS-1)], 1'b1);
          check("frame_done_pos", done_ok, 1'b1);
          check("frame_busy", busy_ok, 1'b1);
          last_parity = s_tx[CPB*9];
          if (sb.size() == 0) begin
            check("unexpected_frame", 1'b0, 1'b1);
          end else begin
            e = sb.pop_front();
            check("frame_data", rx, e.data);
            check("frame_grant", s_grant, e.gid);
          end
          frames_seen++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_raw);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk_raw);
    rst_n = 1'b1;
    sb.delete();
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input bit id, input logic [7:0] d);
    int n = 0;
    while ((id ? req1_ready : req0_ready) !== 1'b1 && n < 500) begin
      @(negedge clk_raw);
      n++;
    end
    check("send_ready", (n < 500), 1'b1);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    @(negedge clk_raw);
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic push(input logic gid, input logic [7:0] d);
    exp_t e;
    e.gid = gid;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < 2000) begin
      @(negedge clk_raw);
      n++;
    end
    check("frames_complete", (frames_seen >= target), 1'b1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00;

    // Single byte with reset-state and start-latency checks
    do_reset();
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_grant", grant_id, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_ready0", req0_ready, 1'b1);
    check("rst_ready1", req1_ready, 1'b1);
    base = frames_seen;
    send(0, 8'h55);
    push(1'b0, 8'h55);
    check("ready0_after_accept", req0_ready, 1'b0);
    check("tx_idle_after_accept", tx, 1'b1);
    @(negedge clk_raw);
    check("tx_high_in_load", tx, 1'b1);
    check("busy_low_in_load", busy, 1'b0);
    @(negedge clk_raw);
    check("tx_low_2_after_accept", tx, 1'b0);
    check("busy_in_start", busy, 1'b1);
    wait_frames(base + 1);
    check("single_frame_count", frames_seen - base, 1);

    // Contention right after reset: requester 0 wins first
    do_reset();
    base = frames_seen;
    fork
      send(0, 8'hA5);
      send(1, 8'h3C);
    join
    push(1'b0, 8'hA5);
    push(1'b1, 8'h3C);
    wait_frames(base + 2);
    check("contention_gap", last_gap, 2);
    check("contention_frames", frames_seen - base, 2);

    // Fairness with both holding registers kept full
    do_reset();
    base = frames_seen;
    push(1'b0, 8'h11);
    push(1'b1, 8'h33);
    push(1'b0, 8'h22);
    push(1'b1, 8'h44);
    fork
      begin send(0, 8'h11); send(0, 8'h22); end
      begin send(1, 8'h33); send(1, 8'h44); end
    join
    wait_frames(base + 4);
    check("fair_gap", last_gap, 2);

    // Refill during own frame
    do_reset();
    base = frames_seen;
    send(0, 8'h01);
    push(1'b0, 8'h01);
    check("refill_ready_idle", req0_ready, 1'b0);
    @(negedge clk_raw);
    check("refill_ready_load", req0_ready, 1'b0);
    @(negedge clk_raw);
    check("refill_ready_after_load", req0_ready, 1'b1);
    repeat (8) @(negedge clk_raw);
    send(0, 8'h02);
    push(1'b0, 8'h02);
    wait_frames(base + 2);
    check("refill_gap", last_gap, 2);

    // Reset during DATA bit 3 aborts the frame
    do_reset();
    send(0, 8'hF0);
    @(negedge clk_raw);
    @(negedge clk_raw);
    repeat (CPB + 3*CPB + 1) @(negedge clk_raw);
    base = frames_seen;
    rst_n = 1'b0;
    @(negedge clk_raw);
    check("abort_tx", tx, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready0", req0_ready, 1'b1);
    check("abort_ready1", req1_ready, 1'b1);
    check("abort_frame_done", frame_done, 1'b0);
    @(negedge clk_raw);
    rst_n = 1'b1;
    sb.delete();
    repeat (10) @(negedge clk_raw);
    check("abort_no_frame", frames_seen - base, 0);
    send(0, 8'h0F);
    push(1'b0, 8'h0F);
    wait_frames(base + 1);

`ifdef UART_TX_PARITY_EN
    // Even parity bit
    do_reset();
    base = frames_seen;
    send(0, 8'h07);
    push(1'b0, 8'h07);
    wait_frames(base + 1);
    check("parity_07", last_parity, 1'b1);
    send(0, 8'h03);
    push(1'b0, 8'h03);
    wait_frames(base + 2);
    check("parity_03", last_parity, 1'b0);
`endif

    repeat (5) @(negedge clk_raw);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
